// File: rtl/rpn_stack_reader.sv
// Operand LIFO for the board-level RPN calculator: push/pop buttons are
// synchronized and edge-detected, pops show the top entry on the LEDs.
module rpn_stack_reader #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         sw,
  input  logic [1:0]               btn,
  output logic [WIDTH-1:0]         ld,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]       sync1_reg, sync2_reg, prev_reg, pulse_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] ld_reg, ld_next;
  logic             empty_reg, full_reg, err_reg, err_next;
  logic             wr_en;
  logic [AW-1:0]    wr_addr, top_idx;
  logic             push, pop;

  // Pulse is registered so a press lands three edges after it is first sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
      pulse_reg <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      pulse_reg <= sync2_reg & ~prev_reg;
    end
  end

  assign push    = pulse_reg[0];
  assign pop     = pulse_reg[1];
  assign top_idx = AW'(count_reg - CW'(1));

  always_comb begin
    count_next = count_reg;
    ld_next    = ld_reg;
    err_next   = err_reg;
    wr_en      = 1'b0;
    wr_addr    = count_reg[AW-1:0];
    if (push && pop) begin
      err_next = 1'b0;
      wr_en    = 1'b1;
      if (!empty_reg) begin
        ld_next = mem_reg[top_idx];
        wr_addr = top_idx;
      end else begin
        wr_addr    = '0;
        count_next = CW'(1);
      end
    end else if (push) begin
      if (full_reg) begin
        err_next = 1'b1;
      end else begin
        wr_en      = 1'b1;
        count_next = count_reg + CW'(1);
        err_next   = 1'b0;
      end
    end else if (pop) begin
      if (empty_reg) begin
        err_next = 1'b1;
      end else begin
        ld_next    = mem_reg[top_idx];
        count_next = count_reg - CW'(1);
        err_next   = 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          mem_reg[gi] <= '0;
        else if (wr_en && wr_addr == AW'(gi))
          mem_reg[gi] <= sw;
      end
    end
  endgenerate

  // Flags are derived from the next count so they never lag the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      ld_reg    <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      ld_reg    <= ld_next;
      empty_reg <= (count_next == '0);
      full_reg  <= (count_next == CW'(DEPTH));
      err_reg   <= err_next;
    end
  end

  assign ld    = ld_reg;
  assign count = count_reg;
  assign empty = empty_reg;
  assign full  = full_reg;
  assign err   = err_reg;

endmodule
